// File: rtl/lsu_misalign_ctrl.sv
// Load/store sequencer: drives a word-organised memory and splits word-crossing accesses
// into two aligned word cycles (or rejects them when ALLOW_MISALIGN is 0).
module lsu_misalign_ctrl #(
   parameter bit ALLOW_MISALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_type,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [29:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned DW = 32;
   localparam int unsigned WAW = 30;

   localparam logic [2:0] T_WORD  = 3'd0;
   localparam logic [2:0] T_HALF  = 3'd1;
   localparam logic [2:0] T_HALFU = 3'd2;
   localparam logic [2:0] T_BYTE  = 3'd3;
   localparam logic [2:0] T_BYTEU = 3'd4;

   typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

   state_t           r_state;
   logic             r_we;
   logic [2:0]       r_type;
   logic [1:0]       r_off;
   logic             r_cross;
   logic [WAW-1:0]   r_waddr;
   logic [3:0]       r_be_hi;
   logic [DW-1:0]    r_wd_hi;
   logic [DW-1:0]    r_word0;

   logic [3:0]       w_mask;
   logic             w_inv;
   logic             w_cross;
   logic             w_err;
   logic [7:0]       w_be2;
   logic [2*DW-1:0]  w_wd2;
   logic [DW-1:0]    w_lo;
   logic [2*DW-1:0]  w_pair;
   logic [DW-1:0]    w_raw;
   logic [DW-1:0]    w_ldata;

   // Request decode: lane mask, crossing, and both words of lane-shifted enables/data
   always_comb begin
      w_mask = 4'h0;
      w_inv  = 1'b0;
      case (req_type)
         T_WORD:          w_mask = 4'hF;
         T_HALF, T_HALFU: w_mask = 4'h3;
         T_BYTE, T_BYTEU: w_mask = 4'h1;
         default:         w_inv  = 1'b1;
      endcase
      w_cross = ((w_mask == 4'hF) && (req_addr[1:0] != 2'd0)) ||
                ((w_mask == 4'h3) && (req_addr[1:0] == 2'd3));
      w_err   = w_inv || (w_cross && !ALLOW_MISALIGN);
      w_be2   = {4'h0, w_mask} << req_addr[1:0];
      w_wd2   = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
   end

   // Load assembly: first word is live in ACC1, captured afterwards; second word live in ACC2
   always_comb begin
      w_lo   = (r_state == ACC1) ? mem_rdata : r_word0;
      w_pair = {mem_rdata, w_lo};
      w_raw  = w_pair[6'({r_off, 3'b000}) +: DW];
      case (r_type)
         T_WORD:  w_ldata = w_raw;
         T_HALF:  w_ldata = {{16{w_raw[15]}}, w_raw[15:0]};
         T_HALFU: w_ldata = {16'h0, w_raw[15:0]};
         T_BYTE:  w_ldata = {{24{w_raw[7]}}, w_raw[7:0]};
         T_BYTEU: w_ldata = {24'h0, w_raw[7:0]};
         default: w_ldata = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_we      <= 1'b0;
         r_type    <= '0;
         r_off     <= '0;
         r_cross   <= 1'b0;
         r_waddr   <= '0;
         r_be_hi   <= '0;
         r_wd_hi   <= '0;
         r_word0   <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_wdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  r_we      <= req_we;
                  r_type    <= req_type;
                  r_off     <= req_addr[1:0];
                  r_cross   <= w_cross;
                  r_waddr   <= req_addr[31:2];
                  r_be_hi   <= w_be2[7:4];
                  r_wd_hi   <= w_wd2[2*DW-1:DW];
                  req_ready <= 1'b0;
                  if (w_err) begin
                     r_state   <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     r_state   <= ACC1;
                     mem_addr  <= req_addr[31:2];
                     mem_be    <= w_be2[3:0];
                     mem_wdata <= w_wd2[DW-1:0];
                     mem_we    <= req_we;
                  end
               end
            end
            ACC1: begin
               r_word0 <= mem_rdata;
               if (r_cross) begin
                  r_state   <= ACC2;
                  mem_addr  <= r_waddr + WAW'(1);
                  mem_be    <= r_be_hi;
                  mem_wdata <= r_wd_hi;
               end else begin
                  r_state   <= RESP;
                  mem_we    <= 1'b0;
                  mem_be    <= '0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= r_we ? '0 : w_ldata;
               end
            end
            ACC2: begin
               r_state   <= RESP;
               mem_we    <= 1'b0;
               mem_be    <= '0;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= r_we ? '0 : w_ldata;
            end
            RESP: begin
               r_state   <= IDLE;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
               req_ready <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
